// File: rtl/change_dispenser.sv
// -----------------------------------------------------------------------------
// change_dispenser
//
// Pays out an overpayment after a sale using $10, $5 and $1 coins. The largest
// coin that fits the remaining amount and is in stock is always chosen. Each
// coin is ejected by a timed solenoid pulse. The block keeps a count of the
// coins in stock for each denomination.
//
// Ports
//   clk          in   clock, rising edge
//   reset        in   asynchronous, active-low
//   start        in   request payout of change_amt (sampled only when idle)
//   change_amt   in   [7:0] dollars to return
//   restock      in   pulse: add one coin of restock_sel
//   restock_sel  in   [1:0] 0=$1, 1=$5, 2=$10, 3=ignored
//   busy         out  payout in progress (through the done cycle)
//   done         out  one-cycle pulse at end of payout
//   short        out  with done, held until next start: payout incomplete
//   eject_10/5/1 out  ejector solenoid drives (registered, never overlap)
//   remaining    out  [7:0] dollars still owed
//   inv_10/5/1   out  [INV_W-1:0] coin inventories
// -----------------------------------------------------------------------------
module change_dispenser #(
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2,
  parameter int INV_W        = 6,
  parameter int INIT_10      = 8,
  parameter int INIT_5       = 8,
  parameter int INIT_1       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       change_amt,
  input  logic             restock,
  input  logic [1:0]       restock_sel,
  output logic             busy,
  output logic             done,
  output logic             short,
  output logic             eject_10,
  output logic             eject_5,
  output logic             eject_1,
  output logic [7:0]       remaining,
  output logic [INV_W-1:0] inv_10,
  output logic [INV_W-1:0] inv_5,
  output logic [INV_W-1:0] inv_1
);

  localparam int CNT_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    PULSE  = 3'd2,
    GAP    = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [7:0]       remaining_reg, remaining_next;
  logic             short_reg, short_next;
  // One-hot coin choice, bit 2 = $10, bit 1 = $5, bit 0 = $1 (same order as inv_reg).
  logic [2:0]       sel_reg, sel_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic [2:0]       eject_reg, eject_next;

  logic [INV_W-1:0] inv_reg [3];   // index 0=$1, 1=$5, 2=$10 (matches restock_sel)

  logic [2:0]       pick;
  logic [7:0]       coin_val;

  // Greedy choice: largest denomination that fits and is in stock.
  always_comb begin
    pick     = 3'b000;
    coin_val = 8'd0;
    if (remaining_reg >= 8'd10 && inv_reg[2] != '0) begin
      pick     = 3'b100;
      coin_val = 8'd10;
    end else if (remaining_reg >= 8'd5 && inv_reg[1] != '0) begin
      pick     = 3'b010;
      coin_val = 8'd5;
    end else if (remaining_reg != 8'd0 && inv_reg[0] != '0) begin
      pick     = 3'b001;
      coin_val = 8'd1;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    remaining_next = remaining_reg;
    short_next     = short_reg;
    sel_next       = sel_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          remaining_next = change_amt;
          short_next     = 1'b0;
          state_next     = SELECT;
        end
      end
      SELECT: begin
        cnt_next = '0;
        if (pick != 3'b000) begin
          remaining_next = remaining_reg - coin_val;
          sel_next       = pick;
          state_next     = PULSE;
        end else begin
          // Nothing payable: either finished or out of suitable coins.
          short_next = (remaining_reg != 8'd0);
          state_next = DONE;
        end
      end
      PULSE: begin
        if (cnt_reg == CNT_W'(PULSE_CYCLES - 1)) begin
          cnt_next   = '0;
          state_next = GAP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      GAP: begin
        if (cnt_reg == CNT_W'(GAP_CYCLES - 1)) begin
          cnt_next   = '0;
          state_next = SELECT;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Outputs are decoded from the next state and registered, so they line
    // up with the state they describe and cannot glitch.
    busy_next  = (state_next != IDLE);
    done_next  = (state_next == DONE);
    eject_next = (state_next == PULSE) ? sel_next : 3'b000;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      remaining_reg <= 8'd0;
      short_reg     <= 1'b0;
      sel_reg       <= 3'b000;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      eject_reg     <= 3'b000;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      remaining_reg <= remaining_next;
      short_reg     <= short_next;
      sel_reg       <= sel_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      eject_reg     <= eject_next;
    end
  end

  // Per-denomination inventory. A restock into a full counter is dropped
  // before it is combined with any decrement, so full + restock + payout
  // lands at max-1.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_inv
      localparam logic [INV_W-1:0] INIT_VAL =
        (gi == 2) ? INV_W'(INIT_10) : (gi == 1) ? INV_W'(INIT_5) : INV_W'(INIT_1);

      logic dec;
      logic inc;

      assign dec = (state_reg == SELECT) && pick[gi];
      assign inc = restock && (restock_sel == 2'(gi)) && (inv_reg[gi] != '1);

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          inv_reg[gi] <= INIT_VAL;
        end else if (inc && !dec) begin
          inv_reg[gi] <= inv_reg[gi] + 1'b1;
        end else if (dec && !inc) begin
          inv_reg[gi] <= inv_reg[gi] - 1'b1;
        end
      end
    end
  endgenerate

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign short     = short_reg;
  assign eject_10  = eject_reg[2];
  assign eject_5   = eject_reg[1];
  assign eject_1   = eject_reg[0];
  assign remaining = remaining_reg;
  assign inv_10    = inv_reg[2];
  assign inv_5     = inv_reg[1];
  assign inv_1     = inv_reg[0];

endmodule

// File: tb/tb_change_dispenser.sv
// -----------------------------------------------------------------------------
// tb_change_dispenser
//
// Directed stimulus for change_dispenser. Each accepted payout pushes its
// hand-computed result into a queue; a monitor watching the DUT pops and
// compares on every done pulse, and also checks ejector pulse shape and order.
// -----------------------------------------------------------------------------
module tb_change_dispenser;

  localparam int PULSE = 4;
  localparam int GAP   = 2;
  localparam int INV_W = 6;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [7:0]       change_amt = 8'd0;
  logic             restock = 1'b0;
  logic [1:0]       restock_sel = 2'd0;
  logic             busy, done, short;
  logic             eject_10, eject_5, eject_1;
  logic [7:0]       remaining;
  logic [INV_W-1:0] inv_10, inv_5, inv_1;

  change_dispenser #(
    .PULSE_CYCLES(PULSE), .GAP_CYCLES(GAP), .INV_W(INV_W),
    .INIT_10(8), .INIT_5(8), .INIT_1(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .change_amt(change_amt),
    .restock(restock), .restock_sel(restock_sel),
    .busy(busy), .done(done), .short(short),
    .eject_10(eject_10), .eject_5(eject_5), .eject_1(eject_1),
    .remaining(remaining), .inv_10(inv_10), .inv_5(inv_5), .inv_1(inv_1)
  );

  always #5 clk = ~clk;

  typedef struct {
    int amt;
    int n10, n5, n1;
    int short_exp;
    int rem;
    int i10, i5, i1;
  } exp_t;

  exp_t exp_q[$];
  int applied = 0;
  int miscompares = 0;

  function automatic void chk(input string name, input int act, input int req);
    applied++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endfunction

  function automatic exp_t mk(input int amt, input int n10, input int n5, input int n1,
                              input int sh, input int rem, input int i10, input int i5,
                              input int i1);
    exp_t e;
    e.amt = amt; e.n10 = n10; e.n5 = n5; e.n1 = n1;
    e.short_exp = sh; e.rem = rem; e.i10 = i10; e.i5 = i5; e.i1 = i1;
    return e;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  int       m_n10, m_n5, m_n1, m_busy_cnt, m_hi, m_lo, m_last;
  logic     m_busy_prev = 1'b0;
  logic [2:0] m_ej_prev = 3'b000;

  always @(negedge clk) begin
    logic [2:0] ej;
    int code;
    exp_t e;
    ej = {eject_10, eject_5, eject_1};
    if (!reset) begin
      m_n10 = 0; m_n5 = 0; m_n1 = 0; m_busy_cnt = 0;
      m_hi = 0; m_lo = -1; m_last = 3;
      m_busy_prev = 1'b0;
      m_ej_prev = 3'b000;
    end else begin
      chk("eject_onehot", int'($countones(ej) <= 1), 1);
      if (busy && !m_busy_prev) begin
        m_n10 = 0; m_n5 = 0; m_n1 = 0; m_busy_cnt = 0;
        m_hi = 0; m_lo = -1; m_last = 3;
      end
      if (busy) m_busy_cnt++;
      if (ej != 3'b000 && m_ej_prev == 3'b000) begin
        code = ej[2] ? 3 : (ej[1] ? 2 : 1);
        chk("greedy_order", int'(code <= m_last), 1);
        m_last = code;
        // Low time between coins is the GAP state plus the SELECT cycle.
        if (m_lo >= 0) chk("low_between_coins", m_lo, GAP + 1);
        if (code == 3) m_n10++;
        else if (code == 2) m_n5++;
        else m_n1++;
        m_hi = 0;
      end
      if (ej != 3'b000) m_hi++;
      if (ej == 3'b000) begin
        if (m_ej_prev != 3'b000) begin
          chk("pulse_width", m_hi, PULSE);
          m_lo = 1;
        end else if (m_lo >= 0) begin
          m_lo++;
        end
      end
      if (done) begin
        chk("busy_at_done", int'(busy), 1);
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          $display("txn amt=%0d coins=%0d/%0d/%0d short=%0d rem=%0d inv=%0d/%0d/%0d busy_cycles=%0d",
                   e.amt, m_n10, m_n5, m_n1, short, remaining, inv_10, inv_5, inv_1, m_busy_cnt);
          chk("n10", m_n10, e.n10);
          chk("n5", m_n5, e.n5);
          chk("n1", m_n1, e.n1);
          chk("short", int'(short), e.short_exp);
          chk("remaining", int'(remaining), e.rem);
          chk("inv_10", int'(inv_10), e.i10);
          chk("inv_5", int'(inv_5), e.i5);
          chk("inv_1", int'(inv_1), e.i1);
          chk("busy_cycles", m_busy_cnt, 7 * (e.n10 + e.n5 + e.n1) + 2);
        end
      end
      m_busy_prev = busy;
      m_ej_prev = ej;
    end
  end

  // ---------------- stimulus ----------------
  // Start held for one edge (E0); optional restock lands on E1, the SELECT cycle.
  task automatic pay(input int amt, input exp_t e, input int rs_sel);
    @(negedge clk);
    start = 1'b1;
    change_amt = 8'(amt);
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    if (rs_sel >= 0) begin
      restock = 1'b1;
      restock_sel = 2'(rs_sel);
    end
    @(negedge clk);
    restock = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !done; i++) @(negedge clk);
    chk("done_timeout", int'(done), 1);
    @(negedge clk);
  endtask

  task automatic do_restock(input int sel);
    @(negedge clk);
    restock = 1'b1;
    restock_sel = 2'(sel);
    @(negedge clk);
    restock = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
  endtask

  task automatic check_inv(input string tag, input int i10, input int i5, input int i1);
    chk({tag, "_inv10"}, int'(inv_10), i10);
    chk({tag, "_inv5"}, int'(inv_5), i5);
    chk({tag, "_inv1"}, int'(inv_1), i1);
  endtask

  initial begin
    int seen;
    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_short", int'(short), 0);
    chk("rst_eject", int'({eject_10, eject_5, eject_1}), 0);
    chk("rst_remaining", int'(remaining), 0);
    check_inv("rst", 8, 8, 16);
    #2 reset = 1'b1;

    // 16 -> $10, $5, $1.
    pay(16, mk(16, 1, 1, 1, 0, 0, 7, 7, 15), -1);
    wait_done(200);
    // Zero amount: done right after SELECT, busy two cycles.
    pay(0, mk(0, 0, 0, 0, 0, 0, 7, 7, 15), -1);
    wait_done(50);
    // 27 with a second start mid-payout that must be ignored.
    pay(27, mk(27, 2, 1, 2, 0, 0, 5, 6, 13), -1);
    repeat (8) @(negedge clk);
    start = 1'b1;
    change_amt = 8'd50;
    @(negedge clk);
    start = 1'b0;
    wait_done(300);

    // Drain to 1/1/2 and force a shortfall.
    do_reset();
    pay(80, mk(80, 8, 0, 0, 0, 0, 0, 8, 16), -1);
    wait_done(600);
    pay(40, mk(40, 0, 8, 0, 0, 0, 0, 0, 16), -1);
    wait_done(600);
    pay(14, mk(14, 0, 0, 14, 0, 0, 0, 0, 2), -1);
    wait_done(600);
    do_restock(2);
    do_restock(1);
    check_inv("preset", 1, 1, 2);
    pay(20, mk(20, 1, 1, 2, 1, 3, 0, 0, 0), -1);
    wait_done(300);
    repeat (5) @(negedge clk);
    chk("short_held", int'(short), 1);
    do_restock(3);
    check_inv("sel3_ignored", 0, 0, 0);
    pay(3, mk(3, 0, 0, 0, 1, 3, 0, 0, 0), -1);
    wait_done(50);
    pay(0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0), -1);
    wait_done(50);

    // Restock saturation and restock colliding with a payout decrement.
    do_reset();
    @(negedge clk);
    restock = 1'b1;
    restock_sel = 2'd0;
    repeat (60) @(negedge clk);
    restock = 1'b0;
    chk("inv1_saturated", int'(inv_1), 63);
    pay(10, mk(10, 1, 0, 0, 0, 0, 8, 8, 63), 2);
    chk("inv10_net_zero", int'(inv_10), 8);
    wait_done(100);
    pay(1, mk(1, 0, 0, 1, 0, 0, 8, 8, 62), 0);
    chk("inv1_sat_dec", int'(inv_1), 62);
    wait_done(100);

    // Reset during a $5 pulse of amt=7: ejector drops at once, no done.
    do_reset();
    @(negedge clk);
    start = 1'b1;
    change_amt = 8'd7;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && !eject_5; i++) @(negedge clk);
    chk("eject5_seen", int'(eject_5), 1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_eject5_low", int'(eject_5), 0);
    chk("async_busy_low", int'(busy), 0);
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_remaining", int'(remaining), 0);
    check_inv("post_rst", 8, 8, 16);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("no_done_after_reset", seen, 0);
    chk("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
